// File: rtl/wb_seq_pkg.sv
// Shared definitions for the writeback sequencer: source codes, FSM state
// encoding, default timeout and the source-readiness decode.
package wb_seq_pkg;

  localparam logic [2:0] SRC_ULA      = 3'd0;
  localparam logic [2:0] SRC_SIGN_EXT = 3'd1;
  localparam logic [2:0] SRC_SHIFT    = 3'd2;
  localparam logic [2:0] SRC_HI       = 3'd3;
  localparam logic [2:0] SRC_LO       = 3'd4;
  localparam logic [2:0] SRC_SL16     = 3'd5;
  localparam logic [2:0] SRC_LS       = 3'd6;
  localparam logic [2:0] SRC_EXCP     = 3'd7;

  localparam int unsigned WB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SRC = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_t;

  // Combinational sources are ready at once; the others wait on their unit.
  function automatic logic src_ready(
    input logic [2:0] src,
    input logic       multdiv_done,
    input logic       shift_done,
    input logic       load_valid
  );
    logic rdy;
    case (src)
      SRC_ULA, SRC_SIGN_EXT, SRC_SL16, SRC_EXCP: rdy = 1'b1;
      SRC_SHIFT:                                 rdy = shift_done;
      SRC_HI, SRC_LO:                            rdy = multdiv_done;
      SRC_LS:                                    rdy = load_valid;
      default:                                   rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// WAIT_SRC dwell counter for the writeback sequencer. Only instantiated when
// WB_SEQ_TIMEOUT_EN is defined. o_expired is high during the
// TIMEOUT_CYCLES-th consecutive enabled cycle after a clear.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last    = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_expired = i_enable && w_last;

  // Clear on entry, count enabled cycles, saturate at the last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts a writeback request, waits for the selected
// source to become ready, then issues a one-cycle register-bank write.
// Optional feature macro: WB_SEQ_TIMEOUT_EN (abandon after TIMEOUT_CYCLES
// cycles in WAIT_SRC and pulse wb_timeout).
module wb_sequencer
  import wb_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wb_req,
  input  logic [2:0] wb_src,
  input  logic [4:0] wb_rd,
  input  logic       multdiv_done,
  input  logic       shift_done,
  input  logic       load_valid,
  input  logic       wb_flush,
  output logic       wb_ack,
  output logic [3:0] MEMtoREG_SELETOR,
  output logic       reg_write,
  output logic [4:0] reg_waddr,
  output logic       wb_busy,
  output logic       wb_done,
  output logic       wb_timeout
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_t  r_state;
  wb_state_t  w_next;
  logic       w_accept;
  logic       w_ready;
  logic [2:0] r_src;
  logic [4:0] r_rd;
  logic       r_reg_write;
  logic       r_done;
  logic       r_busy;

`ifdef WB_SEQ_TIMEOUT_EN
  logic w_in_wait;
  logic w_expired;
  logic w_timeout_fire;
  logic r_timeout;

  assign w_in_wait = (r_state == ST_WAIT_SRC);

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_accept),
    .i_enable (w_in_wait),
    .o_expired(w_expired)
  );

  // Timeout pulse lands in the first IDLE cycle after the abandoned wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_fire;
    end
  end

  assign wb_timeout = r_timeout;
`else
  assign wb_timeout = 1'b0;
`endif

  assign w_ready = src_ready(r_src, multdiv_done, shift_done, load_valid);
  assign wb_ack  = (r_state == ST_IDLE) && wb_req;

  // Next state: flush beats readiness, readiness beats timeout.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
    w_timeout_fire = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (wb_req) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT_SRC;
        end
      end
      ST_WAIT_SRC: begin
        if (wb_flush) begin
          w_next = ST_IDLE;
        end else if (w_ready) begin
          w_next = ST_WRITE;
`ifdef WB_SEQ_TIMEOUT_EN
        end else if (w_expired) begin
          w_next         = ST_IDLE;
          w_timeout_fire = 1'b1;
`endif
        end
      end
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the request on acceptance; register outputs from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src       <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src <= wb_src;
        r_rd  <= wb_rd;
      end
      r_reg_write <= (w_next == ST_WRITE) && (r_rd != '0);
      r_done      <= (w_next == ST_WRITE);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  assign MEMtoREG_SELETOR = {1'b0, r_src};
  assign reg_waddr        = r_rd;
  assign reg_write        = r_reg_write;
  assign wb_done          = r_done;
  assign wb_busy          = r_busy;

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer. The driver predicts the outcome of each
// request from the earliest of flush / source-ready / timeout and queues the
// expected completion; the monitor checks every cycle on the falling edge.
module tb_wb_sequencer;

`ifdef WB_SEQ_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_TO = 64;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int INF = 1000000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wb_req = 1'b0;
  logic [2:0] wb_src = '0;
  logic [4:0] wb_rd = '0;
  logic       multdiv_done = 1'b0;
  logic       shift_done = 1'b0;
  logic       load_valid = 1'b0;
  logic       wb_flush = 1'b0;
  logic       wb_ack;
  logic [3:0] MEMtoREG_SELETOR;
  logic       reg_write;
  logic [4:0] reg_waddr;
  logic       wb_busy;
  logic       wb_done;
  logic       wb_timeout;

  wb_sequencer #(
    .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wb_req          (wb_req),
    .wb_src          (wb_src),
    .wb_rd           (wb_rd),
    .multdiv_done    (multdiv_done),
    .shift_done      (shift_done),
    .load_valid      (load_valid),
    .wb_flush        (wb_flush),
    .wb_ack          (wb_ack),
    .MEMtoREG_SELETOR(MEMtoREG_SELETOR),
    .reg_write       (reg_write),
    .reg_waddr       (reg_waddr),
    .wb_busy         (wb_busy),
    .wb_done         (wb_done),
    .wb_timeout      (wb_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         done;
    bit         tmo;
    bit         rw;
    logic [4:0] rd;
    logic [3:0] sel;
  } ev_t;

  ev_t        q[$];
  int         total = 0;
  int         bad = 0;
  int         bfrom = 1;
  int         bto = 0;
  logic [2:0] exp_src = '0;
  logic [4:0] exp_rd = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: busy window, held select/address, and queued completions.
  ev_t mon_e;
  bit  mon_be;
  always @(negedge clk) begin
    if (reset_n) begin
      mon_be = (cyc >= bfrom) && (cyc <= bto);
      chk("busy", int'(wb_busy), int'(mon_be));
      if (mon_be) begin
        chk("ack_while_busy", int'(wb_ack), 0);
        chk("sel_hold", int'(MEMtoREG_SELETOR), int'({1'b0, exp_src}));
        chk("waddr_hold", int'(reg_waddr), int'(exp_rd));
      end
      if (wb_done || wb_timeout || reg_write) begin
        if (q.size() == 0) begin
          chk("unexpected_event", int'({wb_done, wb_timeout, reg_write}), 0);
        end else begin
          mon_e = q.pop_front();
          chk("event_cycle", cyc, mon_e.cyc);
          chk("wb_done", int'(wb_done), int'(mon_e.done));
          chk("wb_timeout", int'(wb_timeout), int'(mon_e.tmo));
          chk("reg_write", int'(reg_write), int'(mon_e.rw));
          if (mon_e.done) begin
            chk("reg_waddr", int'(reg_waddr), int'(mon_e.rd));
            chk("seletor", int'(MEMtoREG_SELETOR), int'(mon_e.sel));
          end
        end
      end
    end
  end

  // One request. d: cycles after acceptance until the needed unit is ready
  // (0 = never); f_off: flush in cycle N+f_off (0 = none).
  task automatic run_txn(input logic [2:0] src, input logic [4:0] rd, input int d,
                         input int f_off, input bit idle_flush);
    int  n, r, f, t, end_idle, tries;
    bit  needs;
    ev_t e;
    @(posedge clk); #1;
    wb_req = 1'b1; wb_src = src; wb_rd = rd; wb_flush = idle_flush;
    multdiv_done = 1'($urandom); shift_done = 1'($urandom); load_valid = 1'($urandom);
    tries = 0;
    @(negedge clk);
    while (!wb_ack && tries < 4) begin
      @(posedge clk); #1;
      @(negedge clk);
      tries++;
    end
    chk("ack_wait", tries, 0);
    if (!wb_ack) begin
      wb_req = 1'b0; wb_flush = 1'b0;
      return;
    end
    n = cyc;
    needs = (src == 3'd2) || (src == 3'd3) || (src == 3'd4) || (src == 3'd6);
    r = needs ? ((d > 0) ? n + d : INF) : n + 1;
    f = (f_off > 0) ? n + f_off : INF;
    t = TO_EN ? n + TB_TO : INF;
    exp_src = src; exp_rd = rd; bfrom = n + 1;
    if (f <= r && f <= t) begin
      bto = f; end_idle = f + 1;
    end else if (r <= t) begin
      bto = r + 1; end_idle = r + 2;
      e.cyc = r + 1; e.done = 1'b1; e.tmo = 1'b0; e.rw = (rd != 5'd0);
      e.rd = rd; e.sel = {1'b0, src};
      q.push_back(e);
    end else begin
      bto = t; end_idle = t + 1;
      e.cyc = t + 1; e.done = 1'b0; e.tmo = 1'b1; e.rw = 1'b0;
      e.rd = rd; e.sel = {1'b0, src};
      q.push_back(e);
    end
    if (end_idle > n + 300) end_idle = n + 300;
    for (int c = n + 1; c < end_idle; c++) begin
      @(posedge clk); #1;
      wb_req = ($urandom_range(0, 3) == 0);
      wb_src = 3'($urandom); wb_rd = 5'($urandom);
      wb_flush = (c == f);
      multdiv_done = 1'($urandom); shift_done = 1'($urandom); load_valid = 1'($urandom);
      case (src)
        3'd2:       shift_done   = (c >= r);
        3'd3, 3'd4: multdiv_done = (c >= r);
        3'd6:       load_valid   = (c >= r);
        default:    ;
      endcase
    end
  endtask

  task automatic reset_midway();
    int n;
    @(posedge clk); #1;
    wb_req = 1'b1; wb_src = 3'd4; wb_rd = 5'd17; wb_flush = 1'b0;
    multdiv_done = 1'b0; shift_done = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    chk("reset_txn_ack", int'(wb_ack), 1);
    n = cyc;
    exp_src = 3'd4; exp_rd = 5'd17; bfrom = n + 1; bto = n + 100;
    @(posedge clk); #1;
    wb_req = 1'b0;
    @(posedge clk); #2;
    bto = cyc - 1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_reg_write", int'(reg_write), 0);
    chk("rst_mid_done", int'(wb_done), 0);
    chk("rst_mid_timeout", int'(wb_timeout), 0);
    chk("rst_mid_busy", int'(wb_busy), 0);
    chk("rst_mid_sel", int'(MEMtoREG_SELETOR), 0);
    chk("rst_mid_waddr", int'(reg_waddr), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    multdiv_done = 1'b1; shift_done = 1'b1; load_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    multdiv_done = 1'b0; shift_done = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_reg_write", int'(reg_write), 0);
    chk("rst_done", int'(wb_done), 0);
    chk("rst_timeout", int'(wb_timeout), 0);
    chk("rst_busy", int'(wb_busy), 0);
    chk("rst_sel", int'(MEMtoREG_SELETOR), 0);
    chk("rst_waddr", int'(reg_waddr), 0);
    @(posedge clk);
    // Request is already up when reset releases: accepted on the first live edge.
    fork
      begin @(posedge clk); #2; reset_n = 1'b1; end
      run_txn(3'd0, 5'd8, 0, 0, 1'b0);
    join
    run_txn(3'd3, 5'd5, 10, 0, 1'b0);
    run_txn(3'd6, 5'd12, 1, 1, 1'b0);
    run_txn(3'd7, 5'd0, 0, 0, 1'b0);
    run_txn(3'd2, 5'd3, 0, 40, 1'b0);
    run_txn(3'd4, 5'd9, 3, 0, 1'b0);
    run_txn(3'd1, 5'd31, 0, 0, 1'b1);
    reset_midway();
    run_txn(3'd5, 5'd2, 0, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      run_txn(3'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom_range(1, 12),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0,
              1'($urandom_range(0, 4) == 0));
    end
    @(posedge clk); #1;
    wb_req = 1'b0; wb_flush = 1'b0;
    multdiv_done = 1'b0; shift_done = 1'b0; load_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
